// File: rtl/run_packer_8_if.sv
// Tuple-in / packed-word-out bus of the 8-lane run packer.
interface run_packer_8_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  localparam int unsigned WORD_WIDTH = 8 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] i_tuple;
  logic                  i_tuple_valid;
  logic                  i_last;
  logic                  o_tuple_ready;
  logic [WORD_WIDTH-1:0] o_data;
  logic                  o_empty;
  logic                  i_read;
  logic                  o_zero_drop;
  logic [31:0]           o_word_count;

  // Producer/consumer side driving tuples in and popping words out
  modport master (
    output i_tuple, i_tuple_valid, i_last, i_read,
    input  o_tuple_ready, o_data, o_empty, o_zero_drop, o_word_count
  );

  // Packer side
  modport slave (
    input  i_tuple, i_tuple_valid, i_last, i_read,
    output o_tuple_ready, o_data, o_empty, o_zero_drop, o_word_count
  );
endinterface

// File: rtl/run_packer_8.sv
// Packs a serial stream of run tuples into 8-lane words, zero-pads short
// final words, closes each run with an all-zero terminator word and
// presents the result through a 2-entry show-ahead buffer.
module run_packer_8 #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 80
) (
  input logic           i_clk,
  input logic           i_rst_n,
  run_packer_8_if.slave bus
);
  localparam int unsigned LANES      = 8;
  localparam int unsigned WORD_WIDTH = LANES * DATA_WIDTH;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] TERM = 1'b1;

  // The key lives inside the tuple and is only carried through.
  if (KEY_WIDTH > DATA_WIDTH) begin : g_key_check
    $error("KEY_WIDTH must not exceed DATA_WIDTH");
  end

  logic [0:0]                           state, state_nxt;
  logic [2:0]                           idx, idx_nxt;
  logic [LANES-1:0][DATA_WIDTH-1:0]     lane, lane_nxt;
  logic [1:0][WORD_WIDTH-1:0]           entry, entry_nxt;
  logic [1:0]                           count, count_nxt;
  logic [1:0]                           fill_level;
  logic                                 ready_en;
  logic                                 zero_drop, zero_drop_nxt;
  logic [31:0]                          word_count;
  logic                                 push;
  logic [LANES-1:0][DATA_WIDTH-1:0]     push_word;
  logic                                 accept;
  logic                                 pop;
  logic                                 tuple_nz;

  // ready_en keeps the input closed while reset is asserted
  assign bus.o_tuple_ready = ready_en & (state == FILL) & (count < 2'd2);
  assign bus.o_empty       = (count == 2'd0);
  assign bus.o_data        = entry[0];
  assign bus.o_zero_drop   = zero_drop;
  assign bus.o_word_count  = word_count;

  assign accept   = bus.i_tuple_valid & bus.o_tuple_ready;
  assign pop      = bus.i_read & (count != 2'd0);
  assign tuple_nz = (bus.i_tuple != '0);

  // Lane filling, word assembly and run termination
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    lane_nxt      = lane;
    zero_drop_nxt = zero_drop;
    push          = 1'b0;
    push_word     = '0;
    case (state)
      FILL: begin
        if (accept) begin
          if (tuple_nz) begin
            lane_nxt[idx] = bus.i_tuple;
            idx_nxt       = idx + 3'd1;
          end else begin
            zero_drop_nxt = 1'b1;
          end
          // Lanes past the newest tuple are zero so short words come out padded
          for (int k = 0; k < int'(LANES); k++) begin
            if (3'(k) < idx) begin
              push_word[k] = lane[k];
            end else if ((3'(k) == idx) && tuple_nz) begin
              push_word[k] = bus.i_tuple;
            end
          end
          if (tuple_nz && ((idx == 3'd7) || bus.i_last)) begin
            push = 1'b1;
          end else if (!tuple_nz && bus.i_last && (idx != 3'd0)) begin
            push = 1'b1;
          end
          if (push) begin
            idx_nxt = 3'd0;
          end
          if (bus.i_last) begin
            state_nxt = TERM;
          end
        end
      end
      TERM: begin
        // Terminator is the default all-zero push_word
        if (count < 2'd2) begin
          push      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Two-entry in-order buffer; head always sits in entry[0]
  always_comb begin
    entry_nxt  = entry;
    fill_level = count - 2'(pop);
    if (pop) begin
      entry_nxt[0] = entry[1];
    end
    if (push) begin
      entry_nxt[fill_level[0]] = push_word;
    end
    count_nxt = count + 2'(push) - 2'(pop);
  end

  // State, lanes, buffer and status registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= FILL;
      idx        <= 3'd0;
      lane       <= '0;
      entry      <= '0;
      count      <= 2'd0;
      ready_en   <= 1'b0;
      zero_drop  <= 1'b0;
      word_count <= 32'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      lane       <= lane_nxt;
      entry      <= entry_nxt;
      count      <= count_nxt;
      ready_en   <= 1'b1;
      zero_drop  <= zero_drop_nxt;
      word_count <= word_count + 32'(push);
    end
  end
endmodule

// File: tb/tb_run_packer_8.sv
// Scoreboard bench for run_packer_8: a list-based reference packer queues
// expected words on each accepted tuple; popped words are compared in order.
module tb_run_packer_8;
  localparam int unsigned DW    = 128;
  localparam int unsigned LANES = 8;
  localparam int unsigned WW    = LANES * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  run_packer_8_if #(.DATA_WIDTH(DW)) bus ();

  run_packer_8 #(.DATA_WIDTH(DW), .KEY_WIDTH(80)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] m_lanes[$];
  logic [31:0]   m_words = 32'd0;
  bit            m_zero  = 1'b0;

  task automatic model_clear();
    exp_q.delete();
    m_lanes.delete();
    m_words = 32'd0;
    m_zero  = 1'b0;
  endtask

  // Reference packer: collect tuples in a list, emit on 8 or end of run
  task automatic model_accept(input logic [DW-1:0] t, input logic last);
    logic [WW-1:0] w;
    if (t == '0) m_zero = 1'b1;
    else m_lanes.push_back(t);
    if ((m_lanes.size() == LANES) || (last && (m_lanes.size() > 0))) begin
      w = '0;
      for (int k = 0; k < m_lanes.size(); k++) w[k*DW +: DW] = m_lanes[k];
      exp_q.push_back(w);
      m_words++;
      m_lanes.delete();
    end
    if (last) begin
      exp_q.push_back('0);
      m_words++;
    end
  endtask

  // One clock: sample accept/pop at the falling edge, return at posedge+1
  task automatic tick(output bit acc);
    logic [WW-1:0] e;
    int bad;
    @(negedge clk);
    acc = bus.i_tuple_valid && bus.o_tuple_ready;
    if (acc) model_accept(bus.i_tuple, bus.i_last);
    if (bus.i_read && !bus.o_empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got word lane0=%h, expected no word", bus.o_data[DW-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_data !== e) begin
          bad = 0;
          for (int k = LANES - 1; k >= 0; k--)
            if (bus.o_data[k*DW +: DW] !== e[k*DW +: DW]) bad = k;
          n_fail++;
          $display("FAIL scoreboard_word lane %0d: got %h expected %h",
                   bad, bus.o_data[bad*DW +: DW], e[bad*DW +: DW]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] t, input logic last);
    bit acc;
    int n;
    bus.i_tuple_valid = 1'b1;
    bus.i_tuple       = t;
    bus.i_last        = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && (n < 64)) begin
      tick(acc);
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tuple %0h not accepted after %0d cycles", t, n);
    end
    bus.i_tuple_valid = 1'b0;
    bus.i_last        = 1'b0;
    bus.i_tuple       = '0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    bus.i_read = 1'b1;
    n = 0;
    while ((exp_q.size() != 0) && (n < 32)) begin
      tick(acc);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
    tick(acc);
    tick(acc);
    n_checks++;
    if (bus.o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got o_empty=%b expected 1", bus.o_empty);
    end
    n_checks++;
    if (bus.o_word_count !== m_words) begin
      n_fail++;
      $display("FAIL word_count: got %0d expected %0d", bus.o_word_count, m_words);
    end
  endtask

  task automatic apply_reset();
    rst_n             = 1'b0;
    bus.i_tuple_valid = 1'b0;
    bus.i_tuple       = '0;
    bus.i_last        = 1'b0;
    bus.i_read        = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_tuple_valid = 1'b0;
    bus.i_tuple       = '0;
    bus.i_last        = 1'b0;
    bus.i_read        = 1'b0;
    rst_n             = 1'b0;
    #12;
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.o_empty); end
    n_checks++; if (bus.o_tuple_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.o_tuple_ready); end
    n_checks++; if (bus.o_zero_drop !== 1'b0) begin n_fail++; $display("FAIL reset_zero_drop: got %b expected 0", bus.o_zero_drop); end
    n_checks++; if (bus.o_word_count !== 32'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d expected 0", bus.o_word_count); end
    apply_reset();
    n_checks++; if (bus.o_tuple_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", bus.o_tuple_ready); end
  endtask

  task automatic test_full_run();
    bit acc;
    int low;
    apply_reset();
    bus.i_read = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.o_tuple_ready) low++;
      tick(acc);
    end
    n_checks++; if (low != 1) begin n_fail++; $display("FAIL full_run_term_cycles: got %0d expected 1", low); end
    drain();
    n_checks++; if (bus.o_word_count !== 32'd2) begin n_fail++; $display("FAIL full_run_count: got %0d expected 2", bus.o_word_count); end
  endtask

  task automatic test_short_run();
    bus.i_read = 1'b1;
    send(DW'(5), 1'b0);
    send(DW'(6), 1'b0);
    send(DW'(7), 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    bit acc;
    apply_reset();
    bus.i_read = 1'b0;
    for (int i = 1; i <= 16; i++) send(DW'(i), 1'b0);
    n_checks++; if (bus.o_tuple_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", bus.o_tuple_ready); end
    tick(acc);
    tick(acc);
    n_checks++; if (bus.o_tuple_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %b expected 0", bus.o_tuple_ready); end
    n_checks++; if (bus.o_word_count !== 32'd2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", bus.o_word_count); end
    bus.i_read = 1'b1;
    tick(acc);
    bus.i_read = 1'b0;
    n_checks++; if (bus.o_tuple_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b expected 1", bus.o_tuple_ready); end
    for (int i = 17; i <= 20; i++) send(DW'(i), i == 20);
    tick(acc);
    tick(acc);
    n_checks++; if (bus.o_tuple_ready !== 1'b0) begin n_fail++; $display("FAIL bp_term_wait_ready: got %b expected 0", bus.o_tuple_ready); end
    drain();
  endtask

  task automatic test_zero_drop();
    apply_reset();
    bus.i_read = 1'b1;
    send(DW'(9), 1'b0);
    send(DW'(0), 1'b0);
    n_checks++; if (bus.o_zero_drop !== 1'b1) begin n_fail++; $display("FAIL zero_drop_set: got %b expected 1", bus.o_zero_drop); end
    send(DW'(10), 1'b1);
    drain();
    send(DW'(0), 1'b1);
    drain();
    n_checks++; if (bus.o_zero_drop !== m_zero) begin n_fail++; $display("FAIL zero_drop_sticky: got %b expected %b", bus.o_zero_drop, m_zero); end
  endtask

  task automatic test_back_to_back();
    bus.i_read = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
    send(DW'(42), 1'b1);
    drain();
  endtask

  task automatic test_reset_mid();
    bit acc;
    apply_reset();
    bus.i_read = 1'b0;
    send(DW'(3), 1'b0);
    send(DW'(4), 1'b1);
    tick(acc);
    bus.i_read = 1'b1;
    tick(acc);
    bus.i_read = 1'b0;
    for (int i = 11; i <= 15; i++) send(DW'(i), 1'b0);
    n_checks++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL mid_buffered: got o_empty=%b expected 0", bus.o_empty); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_empty: got %b expected 1", bus.o_empty); end
    n_checks++; if (bus.o_word_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", bus.o_word_count); end
    n_checks++; if (bus.o_tuple_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", bus.o_tuple_ready); end
    apply_reset();
    bus.i_read = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(100 + i), i == 8);
    drain();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_short_run();
    test_backpressure();
    test_zero_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
